// File: rtl/comp_data_pair_fifo_if.sv
// Stream and control bundle for the compare-data operand FIFO: the PIO-side
// words and strobes in, plus the head-of-queue valid/ready stream and status out.
interface comp_data_pair_fifo_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
);
   logic [31:0] data_hi;
   logic [31:0] data_lo;
   logic        commit;
   logic        clear;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [AW:0] level;
   logic        full;
   logic        overflow;

   modport master (
      output data_hi, data_lo, commit, clear, m_ready,
      input  m_data, m_valid, level, full, overflow
   );

   modport slave (
      input  data_hi, data_lo, commit, clear, m_ready,
      output m_data, m_valid, level, full, overflow
   );
endinterface

// File: rtl/comp_data_pair_fifo.sv
// Captures {data_hi,data_lo} on each rising edge of commit into a small FIFO
// and streams the operands out show-ahead over valid/ready.

module comp_data_pair_fifo_chk #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic          clk,
   input logic          reset_n,
   input logic          clear,
   input logic [AW:0]   level,
   input logic          full,
   input logic          m_valid,
   input logic          overflow
);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   a_level_range: assert property (@(posedge clk) disable iff (!reset_n)
      level <= FULL_LEVEL);
   a_full_match: assert property (@(posedge clk) disable iff (!reset_n)
      full == (level == FULL_LEVEL));
   a_valid_match: assert property (@(posedge clk) disable iff (!reset_n)
      m_valid == (level != {(AW+1){1'b0}}));
   a_overflow_sticky: assert property (@(posedge clk) disable iff (!reset_n)
      (overflow && !clear) |=> overflow);
endmodule

module comp_data_pair_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic                  clk,
   input logic                  reset_n,
   comp_data_pair_fifo_if.slave bus
);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [63:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   level_r;
   logic          overflow_r;
   logic          commit_d_r;

   logic          push_req_s;
   logic          pop_s;
   logic          full_s;
   logic          valid_s;
   logic          push_ok_s;
   logic          drop_s;
   logic          wr_en_s;
   logic [AW-1:0] wr_ptr_nxt_s;
   logic [AW-1:0] rd_ptr_nxt_s;
   logic [AW:0]   level_nxt_s;
   logic          overflow_nxt_s;

   // Handshake decode; a full FIFO still accepts a push when the head leaves that cycle.
   always_comb begin
      full_s     = (level_r == FULL_LEVEL);
      valid_s    = (level_r != {(AW+1){1'b0}});
      push_req_s = bus.commit & ~commit_d_r;
      pop_s      = valid_s & bus.m_ready;
      push_ok_s  = push_req_s & (~full_s | pop_s);
      drop_s     = push_req_s & full_s & ~pop_s;
   end

   // Next-state for pointers, level and overflow; clear overrides push and pop.
   always_comb begin
      wr_ptr_nxt_s   = wr_ptr_r;
      rd_ptr_nxt_s   = rd_ptr_r;
      level_nxt_s    = level_r;
      overflow_nxt_s = overflow_r;
      wr_en_s        = 1'b0;
      if (bus.clear) begin
         wr_ptr_nxt_s   = {AW{1'b0}};
         rd_ptr_nxt_s   = {AW{1'b0}};
         level_nxt_s    = {(AW+1){1'b0}};
         overflow_nxt_s = 1'b0;
         wr_en_s        = 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_en_s      = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
         end else begin
            wr_en_s      = 1'b0;
            wr_ptr_nxt_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_nxt_s = rd_ptr_r;
         end
         case ({push_ok_s, pop_s})
            2'b10:   level_nxt_s = level_r + (AW+1)'(1);
            2'b01:   level_nxt_s = level_r - (AW+1)'(1);
            default: level_nxt_s = level_r;
         endcase
         if (drop_s) begin
            overflow_nxt_s = 1'b1;
         end else begin
            overflow_nxt_s = overflow_r;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_d_r <= 1'b0;
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
      end else begin
         commit_d_r <= bus.commit;
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         level_r    <= level_nxt_s;
         overflow_r <= overflow_nxt_s;
      end
   end

   // Operand storage; zeroed on reset so the idle head reads as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 64'h0;
         end
      end else if (wr_en_s) begin
         mem_r[wr_ptr_r] <= {bus.data_hi, bus.data_lo};
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   assign bus.m_data   = mem_r[rd_ptr_r];
   assign bus.m_valid  = valid_s;
   assign bus.level    = level_r;
   assign bus.full     = full_s;
   assign bus.overflow = overflow_r;

   comp_data_pair_fifo_chk #(.DEPTH(DEPTH), .AW(AW)) u_chk (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (bus.clear),
      .level    (level_r),
      .full     (full_s),
      .m_valid  (valid_s),
      .overflow (overflow_r)
   );
endmodule

// File: tb/tb_comp_data_pair_fifo.sv
// Self-checking bench: fixed vector table, hand corner sequences, and random
// traffic compared against a queue-based reference model.
module tb_comp_data_pair_fifo;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   comp_data_pair_fifo_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
   comp_data_pair_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic        commit;
      logic        clear;
      logic        ready;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        exp_valid;
      logic [63:0] exp_data;
      int          exp_level;
      logic        exp_full;
      logic        exp_ovf;
   } vec_t;

   vec_t        tbl [7];
   logic [63:0] mq [$];
   logic        m_ovf;
   logic        m_prev;
   int          checks = 0;
   int          passes = 0;
   logic [63:0] vals [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_in(input logic c, input logic clr, input logic rdy,
                         input logic [31:0] hi, input logic [31:0] lo);
      bus.commit  = c;
      bus.clear   = clr;
      bus.m_ready = rdy;
      bus.data_hi = hi;
      bus.data_lo = lo;
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b0;
   endtask

   // Reference: rising commit enqueues; a full queue drops unless the head leaves.
   task automatic model_update();
      logic push, pop, was_full;
      push     = bus.commit & ~m_prev;
      pop      = (mq.size() != 0) & bus.m_ready;
      was_full = (mq.size() == DEPTH);
      if (bus.clear) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else mq.push_back({bus.data_hi, bus.data_lo});
         end
      end
      m_prev = bus.commit;
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 64'(bus.m_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk({tag, ".data"}, bus.m_data, mq[0]);
      chk({tag, ".level"}, 64'(bus.level), 64'(mq.size()));
      chk({tag, ".full"}, 64'(bus.full), 64'(mq.size() == DEPTH));
      chk({tag, ".ovf"}, 64'(bus.overflow), 64'(m_ovf));
   endtask

   task automatic pulse(input logic [63:0] v);
      set_in(1'b1, 1'b0, 1'b0, v[63:32], v[31:0]);
      step();
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
   endtask

   task automatic do_clear();
      set_in(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      step();
      bus.clear = 1'b0;
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b1, 64'h1111111122222222, 1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h33333333, 32'h44444444, 1'b1, 64'h1111111122222222, 1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h55555555, 32'h66666666, 1'b1, 64'h1111111122222222, 1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b1, 64'hAAAAAAAABBBBBBBB, 1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 0, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 32'hCCCCCCCC, 32'hDDDDDDDD, 1'b1, 64'hCCCCCCCCDDDDDDDD, 1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 0, 1'b0, 1'b0};

      reset_n = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      chk("rst.valid", 64'(bus.m_valid), 64'd0);
      chk("rst.data", bus.m_data, 64'd0);
      chk("rst.level", 64'(bus.level), 64'd0);
      chk("rst.full", 64'(bus.full), 64'd0);
      chk("rst.ovf", 64'(bus.overflow), 64'd0);

      // First capture is visible one cycle after the commit edge.
      set_in(1'b1, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0);
      step();
      chk("t1.valid", 64'(bus.m_valid), 64'd1);
      chk("t1.data", bus.m_data, 64'h123456789ABCDEF0);
      chk("t1.level", 64'(bus.level), 64'd1);

      for (int i = 0; i < 9; i++) step();
      chk("t2.held_level", 64'(bus.level), 64'd1);
      check_model("t2");

      bus.commit = 1'b0;
      do_clear();
      for (int i = 0; i < 7; i++) begin
         set_in(tbl[i].commit, tbl[i].clear, tbl[i].ready, tbl[i].hi, tbl[i].lo);
         step();
         chk($sformatf("tbl%0d.valid", i), 64'(bus.m_valid), 64'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) chk($sformatf("tbl%0d.data", i), bus.m_data, tbl[i].exp_data);
         chk($sformatf("tbl%0d.level", i), 64'(bus.level), 64'(tbl[i].exp_level));
         chk($sformatf("tbl%0d.full", i), 64'(bus.full), 64'(tbl[i].exp_full));
         chk($sformatf("tbl%0d.ovf", i), 64'(bus.overflow), 64'(tbl[i].exp_ovf));
      end
      bus.clear = 1'b0;

      // Five pushes into a four-deep FIFO: the fifth is dropped.
      for (int i = 0; i < 5; i++) vals[i] = {32'hA0000000 + 32'(i), 32'h0F0F0000 + 32'(i * 3)};
      for (int i = 0; i < 5; i++) pulse(vals[i]);
      chk("t3.level", 64'(bus.level), 64'd4);
      chk("t3.full", 64'(bus.full), 64'd1);
      chk("t3.ovf", 64'(bus.overflow), 64'd1);
      bus.m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3.drain%0d", i), bus.m_data, vals[i]);
         step();
         check_model("t3d");
      end
      chk("t3.empty", 64'(bus.level), 64'd0);

      // Full FIFO with push and pop in the same cycle.
      do_clear();
      for (int i = 0; i < 4; i++) pulse(vals[i] ^ 64'hFFFF0000FFFF0000);
      set_in(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
      step();
      chk("t4.level", 64'(bus.level), 64'd4);
      chk("t4.full", 64'(bus.full), 64'd1);
      chk("t4.ovf", 64'(bus.overflow), 64'd0);
      chk("t4.head", bus.m_data, vals[1] ^ 64'hFFFF0000FFFF0000);
      set_in(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) chk("t4.tail", bus.m_data, 64'hDEADBEEFCAFEF00D);
         step();
         check_model("t4d");
      end

      // Clear beats a simultaneous commit edge and resets overflow.
      do_clear();
      for (int i = 0; i < 5; i++) pulse(vals[i]);
      set_in(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
      chk("t5.level3", 64'(bus.level), 64'd3);
      chk("t5.ovf1", 64'(bus.overflow), 64'd1);
      set_in(1'b1, 1'b1, 1'b0, 32'h77777777, 32'h88888888);
      step();
      chk("t5.level", 64'(bus.level), 64'd0);
      chk("t5.valid", 64'(bus.m_valid), 64'd0);
      chk("t5.ovf", 64'(bus.overflow), 64'd0);
      bus.clear = 1'b0;
      step();
      chk("t5.no_repush", 64'(bus.level), 64'd0);
      bus.commit = 1'b0;
      step();

      // Asynchronous reset mid-cycle with three entries held.
      for (int i = 0; i < 3; i++) pulse(vals[i]);
      chk("t6.level3", 64'(bus.level), 64'd3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6.valid", 64'(bus.m_valid), 64'd0);
      chk("t6.level", 64'(bus.level), 64'd0);
      chk("t6.data", bus.m_data, 64'd0);
      chk("t6.ovf", 64'(bus.overflow), 64'd0);
      #2;
      reset_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_model("t6r");
      set_in(1'b1, 1'b0, 1'b0, 32'h0BADC0DE, 32'h13579BDF);
      step();
      chk("t6.after", bus.m_data, 64'h0BADC0DE13579BDF);
      check_model("t6a");

      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 2) == 0), $urandom, $urandom);
         step();
         check_model("rnd");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
